// File: rtl/apb_req_arbiter_pkg.sv
// Shared types and helpers for the APB requester arbiter.
package apb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } arb_state_e;

    // Width of the ACCESS-phase wait counter; it must hold TIMEOUT-1.
    function automatic int cnt_width(input int timeout);
        return (timeout > 2) ? $clog2(timeout) : 1;
    endfunction

    // Low bit of requester idx inside a packed per-requester bus.
    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/apb_req_arbiter_if.sv
// APB completer-facing bus shared by all requesters.
interface apb_req_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              psel;
    logic              penable;
    logic [ADDR_W-1:0] paddr;
    logic              pwrite;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;

    modport master (
        output psel, penable, paddr, pwrite, pwdata,
        input  prdata, pready
    );

    modport slave (
        input  psel, penable, paddr, pwrite, pwdata,
        output prdata, pready
    );
endinterface

// File: rtl/apb_req_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request searching upward from ptr+1.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int IDX_W = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               valid
);

    always_comb begin
        int unsigned base;
        int unsigned cand;
        logic [IDX_W-1:0] cand_idx;
        grant     = '0;
        grant_idx = '0;
        valid     = 1'b0;
        base      = 32'(ptr);
        cand      = 0;
        cand_idx  = '0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            cand     = (base + off) % NUM_REQ;
            cand_idx = IDX_W'(cand);
            if (!valid && req[cand_idx]) begin
                valid     = 1'b1;
                grant_idx = cand_idx;
            end
        end
        if (valid) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/apb_req_arbiter.sv
// Shares one APB master port between NUM_REQ requesters, round-robin,
// one SETUP/ACCESS transfer at a time with an ACCESS-phase timeout.
module apb_req_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                      pclk,
    input  logic                      preset_n,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ-1:0]        write_i,
    input  logic [NUM_REQ*ADDR_W-1:0] addr_i,
    input  logic [NUM_REQ*DATA_W-1:0] wdata_i,
    output logic [NUM_REQ-1:0]        done_o,
    output logic                      err_o,
    output logic [DATA_W-1:0]         rdata_o,
    apb_req_arbiter_if.master         apb
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = cnt_width(TIMEOUT);

    arb_state_e         state;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   grant_idx;
    logic [NUM_REQ-1:0] grant_oh;
    logic [CNT_W-1:0]   cnt;

    logic               psel_q;
    logic               penable_q;
    logic [ADDR_W-1:0]  paddr_q;
    logic               pwrite_q;
    logic [DATA_W-1:0]  pwdata_q;

    logic [NUM_REQ-1:0] win_grant;
    logic [IDX_W-1:0]   win_idx;
    logic               win_valid;

    logic               finish;
    logic               timeout_hit;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req       (req_i),
        .ptr       (ptr),
        .grant     (win_grant),
        .grant_idx (win_idx),
        .valid     (win_valid)
    );

    assign timeout_hit = (state == ACCESS) && !apb.pready && (cnt == CNT_W'(TIMEOUT - 1));
    assign finish      = (state == ACCESS) && (apb.pready || (cnt == CNT_W'(TIMEOUT - 1)));

    assign done_o  = finish ? grant_oh : '0;
    assign err_o   = timeout_hit;
    assign rdata_o = (finish && !timeout_hit) ? apb.prdata : '0;

    assign apb.psel    = psel_q;
    assign apb.penable = penable_q;
    assign apb.paddr   = paddr_q;
    assign apb.pwrite  = pwrite_q;
    assign apb.pwdata  = pwdata_q;

    // psel/penable are registered alongside the next state so the bus side
    // never sees a combinational path from req_i.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state     <= IDLE;
            ptr       <= IDX_W'(NUM_REQ - 1);
            grant_idx <= '0;
            grant_oh  <= '0;
            cnt       <= '0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            paddr_q   <= '0;
            pwrite_q  <= 1'b0;
            pwdata_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    psel_q    <= 1'b0;
                    penable_q <= 1'b0;
                    if (win_valid) begin
                        grant_idx <= win_idx;
                        grant_oh  <= win_grant;
                        paddr_q   <= addr_i[slice_lo(int'(win_idx), ADDR_W) +: ADDR_W];
                        pwdata_q  <= wdata_i[slice_lo(int'(win_idx), DATA_W) +: DATA_W];
                        pwrite_q  <= write_i[win_idx];
                        psel_q    <= 1'b1;
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    cnt       <= '0;
                    state     <= ACCESS;
                end
                ACCESS: begin
                    if (finish) begin
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        ptr       <= grant_idx;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    psel_q    <= 1'b0;
                    penable_q <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
